modn_down_counter: RTL
======================

Name: modn_down_counter

Overview:
Synchronous, programmable modulo-N down counter. Counts MOD_N-1 down to 0, then wraps back to N-1. It is the down-counting counterpart of the team's mod-N up counter. Clock dividers, timeout timers and sequencers use it where a terminal-count pulse and a runtime-changeable modulus are needed. All state changes on the rising edge of a single clock; there are no ripple clocks and no asynchronous clears.

Parameters:
WIDTH, 3, count register width in bits
MOD_N, 5, reset-time modulus; legal range 2..2^WIDTH; an illegal value is an elaboration error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; decrement (or wrap) on a clock edge when high
load  input  1  load count from load_val; takes priority over en
load_val  input  WIDTH  value to load, clamped to the active modulus
mod_wr  input  1  write a new modulus into the shadow register
mod_n_in  input  WIDTH+1  new modulus value; legal range 2..2^WIDTH
count  output  WIDTH  current count value
zero  output  1  combinational; high when count==0
tc  output  1  registered terminal-count pulse; high for exactly one cycle after a wrap
mod_pend  output  1  high while a shadow modulus is waiting to take effect

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Internal state:
  - count
  - active_mod (WIDTH+1 bits)
  - shadow_mod (WIDTH+1 bits)
  - pend flag, which drives mod_pend
  - tc register
- Reset (rst=1 at an edge):
  - count=MOD_N-1, active_mod=MOD_N, shadow_mod=MOD_N.
  - pend=0, tc=0.
  - All other inputs are ignored that cycle.
  - Reset asserted mid-count or with a pending modulus discards the pending modulus.
- Count-path priority per edge: rst > load > en > hold.
- load=1:
  - count <= (load_val >= active_mod) ? active_mod-1 : load_val.
  - tc <= 0.
  - A pending modulus is not applied.
- en=1, load=0, count!=0: count <= count-1; tc <= 0.
- en=1, load=0, count==0 (wrap):
  - If pend=1 (its value before this edge): active_mod <= shadow_mod, count <= shadow_mod-1, pend <= 0.
  - Otherwise: count <= active_mod-1.
  - tc <= 1.
- en=0, load=0: count holds; tc <= 0.
- tc is high in the cycle after each wrap, for one cycle only. With en held high, tc pulses once every active_mod cycles.
- zero = (count==0), combinational from the count register. It stays high while the counter holds at 0.
- Modulus write (mod_wr=1), evaluated independently of the count path but under rst:
  - mod_n_in in 2..2^WIDTH: shadow_mod <= mod_n_in, pend <= 1.
  - mod_n_in outside that range: the write is ignored entirely (shadow and pend unchanged).
  - A second legal write before the wrap overwrites the shadow; the last write wins.
  - A mod_wr in the same cycle as a wrap updates the shadow and sets pend=1. It does not affect this wrap, which uses the pre-edge pend/shadow. It applies at the following wrap.
- Arithmetic: count width is WIDTH. Modulus values are WIDTH+1 bits so that 2^WIDTH is representable; active_mod-1 always fits in WIDTH bits. The decrement never underflows, because the count==0 case always takes the wrap path.
- Latency: count, tc and mod_pend change one edge after their causing inputs; zero follows count combinationally.

Test Plan:
1. Reset with MOD_N=5, WIDTH=3, then en=1 for 12 cycles -> count=4,3,2,1,0,4,3,2,1,0,4,3. tc high only in the two cycles after 0->4. zero high exactly when count=0.
2. en toggled 1,0,0,1 starting from count=3 -> count 2,2,2,1. tc stays 0. Then load=1, load_val=6 -> count=4 (clamped). load=1, load_val=2 with en=1 -> count=2 (load wins).
3. At count=3, mod_wr=1, mod_n_in=3 -> mod_pend=1, count continues 2,1,0. Wrap gives count=2 and mod_pend=0. Sequence then continues 1,0,2,1,0 with tc every 3 cycles.
4. Illegal writes mod_n_in=1, then mod_n_in=9 (WIDTH=3) -> mod_pend stays 0 and the wrap value stays 4. Legal write mod_n_in=8 -> after the next wrap, the count sequence is 7..0.
5. mod_wr=1, mod_n_in=2 in the same cycle as a wrap from 0 with modulus 5 -> count=4, mod_pend=1. The next wrap gives count=1, then 0,1,0.
6. rst=1 mid-count (count=2, mod_pend=1) -> next edge count=4, tc=0, mod_pend=0. After rst deasserts, counting resumes 3,2,... with modulus 5.

Source files
------------

// File: rtl/modn_down_counter.sv
// Programmable modulo-N down counter: counts active_mod-1 down to 0, then wraps.
// Latency: count/tc/mod_pend update one clk edge after their cause; zero is combinational from count.
// Backpressure: none; en gates counting and load overrides en.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        decrement (or wrap at 0) when high
//   load      load count from load_val (clamped to active_mod-1); beats en
//   load_val  value to load
//   mod_wr    write mod_n_in into the shadow modulus (ignored if out of range)
//   mod_n_in  new modulus, legal 2..2^WIDTH
//   count     current count
//   zero      count == 0
//   tc        one-cycle pulse in the cycle after a wrap
//   mod_pend  shadow modulus waiting for the next wrap
module modn_down_counter #(
    parameter int WIDTH = 3,
    parameter int MOD_N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH:0]   mod_n_in,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             mod_pend
);

    generate
        if (WIDTH < 1 || MOD_N < 2 || MOD_N > (1 << WIDTH)) begin : g_bad_param
            $error("modn_down_counter: MOD_N must be in 2..2^WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   RST_MOD   = (WIDTH+1)'(MOD_N);
    localparam logic [WIDTH:0]   MAX_MOD   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   MIN_MOD   = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]   RST_TOP_W = RST_MOD - 1'b1;
    localparam logic [WIDTH-1:0] RST_TOP   = RST_TOP_W[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   active_mod_q, active_mod_d;
    logic [WIDTH:0]   shadow_mod_q, shadow_mod_d;
    logic             pend_q, pend_d;
    logic             tc_q, tc_d;

    // Top-of-range values. Any legal modulus minus one fits in WIDTH bits,
    // so dropping the MSB of the (WIDTH+1)-bit difference loses nothing.
    logic [WIDTH:0]   active_top_w;
    logic [WIDTH:0]   shadow_top_w;
    logic             wrap;
    logic             mod_legal;

    assign active_top_w = active_mod_q - 1'b1;
    assign shadow_top_w = shadow_mod_q - 1'b1;
    assign wrap         = en && !load && (count_q == '0);
    assign mod_legal    = (mod_n_in >= MIN_MOD) && (mod_n_in <= MAX_MOD);

    always_comb begin
        count_d      = count_q;
        active_mod_d = active_mod_q;
        shadow_mod_d = shadow_mod_q;
        pend_d       = pend_q;
        tc_d         = 1'b0;

        if (load) begin
            // Clamp into the current range; a pending modulus is left alone.
            if ({1'b0, load_val} >= active_mod_q) begin
                count_d = active_top_w[WIDTH-1:0];
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (wrap) begin
                tc_d = 1'b1;
                if (pend_q) begin
                    active_mod_d = shadow_mod_q;
                    count_d      = shadow_top_w[WIDTH-1:0];
                    pend_d       = 1'b0;
                end else begin
                    count_d = active_top_w[WIDTH-1:0];
                end
            end else begin
                count_d = count_q - 1'b1;
            end
        end

        // Evaluated after the wrap so a same-cycle write re-arms pend for the
        // following wrap; this wrap already consumed the pre-edge shadow.
        if (mod_wr && mod_legal) begin
            shadow_mod_d = mod_n_in;
            pend_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= RST_TOP;
            active_mod_q <= RST_MOD;
            shadow_mod_q <= RST_MOD;
            pend_q       <= 1'b0;
            tc_q         <= 1'b0;
        end else begin
            count_q      <= count_d;
            active_mod_q <= active_mod_d;
            shadow_mod_q <= shadow_mod_d;
            pend_q       <= pend_d;
            tc_q         <= tc_d;
        end
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    assign tc       = tc_q;
    assign mod_pend = pend_q;

endmodule
